// File: rtl/irq_vector_pkg.sv
// Shared opcodes, FSM encoding and vector helpers for the interrupt vector scheduler.
package irq_vector_pkg;

    typedef enum logic [1:0] {
        OpGetVector  = 2'd0,
        OpEoi        = 2'd1,
        OpWriteMask  = 2'd2,
        OpReadStatus = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StResp = 2'd2
    } state_e;

    localparam logic [31:0] NO_IRQ_VECTOR = 32'h8000_0000;
    localparam int unsigned VECTOR_STRIDE = 8;

    // Vector for a winning source; bit 31 is reserved for the no-interrupt flag.
    function automatic logic [31:0] make_vector(input int unsigned idx);
        return (idx * VECTOR_STRIDE) & ~NO_IRQ_VECTOR;
    endfunction

    // Index of the lowest set bit; 0 when v is zero, so callers must guard that case.
    function automatic int unsigned lowest_set(input logic [31:0] v);
        int unsigned r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 32'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_vector_scheduler_if.sv
// Custom-instruction bus between the Nios II core (master) and the scheduler (slave).
interface irq_vector_scheduler_if #(
    parameter int unsigned NUM_IRQ = 32
) ();
    logic               clk_en;
    logic               start;
    logic [1:0]         n;
    logic [31:0]        dataa;
    logic [NUM_IRQ-1:0] irq;
    logic [31:0]        result;
    logic               done;

    modport master (
        output clk_en, start, n, dataa, irq,
        input  result, done
    );

    modport slave (
        input  clk_en, start, n, dataa, irq,
        output result, done
    );
endinterface

// File: rtl/irq_group_encoder.sv
// Lowest-set-bit finder for one scan group.
module irq_group_encoder #(
    parameter int unsigned Width = 8,
    localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] bits_i,
    output logic             any_o,
    output logic [IdxW-1:0]  idx_o
);
    // Scan high to low so the last hit is the lowest set bit.
    always_comb begin
        idx_o = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (bits_i[i]) idx_o = IdxW'(i);
        end
    end

    assign any_o = |bits_i;
endmodule

// File: rtl/irq_vector_scheduler.sv
// Interrupt vector scheduler: snapshot pending sources, scan groups for the lowest eligible
// index, track in-service nesting and answer Nios II custom-instruction commands.
module irq_vector_scheduler
    import irq_vector_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 32,
    parameter int unsigned SCAN_WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    irq_vector_scheduler_if.slave bus
);
    localparam int unsigned NUM_GROUPS = NUM_IRQ / SCAN_WIDTH;
    localparam int unsigned GrpW       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned IdxW       = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;
    localparam logic [GrpW-1:0]    LastGrp = GrpW'(NUM_GROUPS - 1);
    localparam logic [NUM_IRQ-1:0] OneIrq  = NUM_IRQ'(1);

    state_e             state_q;
    logic [GrpW-1:0]    grp_q;
    logic [NUM_IRQ-1:0] snap_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] isr_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic               done_q;
    logic [31:0]        result_q;

    logic [NUM_IRQ-1:0]    below_isr;
    logic [NUM_IRQ-1:0]    get_snap;
    logic [SCAN_WIDTH-1:0] grp_bits;
    logic                  enc_any;
    logic [IdxW-1:0]       enc_idx;
    int unsigned           grp_base;
    int unsigned           win_idx;
    int unsigned           isr_low;

    // Isolating the lowest in-service bit and subtracting one yields every index below it;
    // with nothing in service the subtraction wraps to all ones.
    assign below_isr = (isr_q & (~isr_q + OneIrq)) - OneIrq;
    assign get_snap  = pend_q & mask_q & below_isr & {NUM_IRQ{bus.dataa[0]}};

    assign grp_base = 32'(grp_q) * SCAN_WIDTH;
    assign grp_bits = SCAN_WIDTH'(snap_q >> grp_base);
    assign win_idx  = grp_base + 32'(enc_idx);
    assign isr_low  = lowest_set(32'(isr_q));

    irq_group_encoder #(
        .Width (SCAN_WIDTH)
    ) u_group_encoder (
        .bits_i (grp_bits),
        .any_o  (enc_any),
        .idx_o  (enc_idx)
    );

    // Command FSM plus all scheduler state; everything freezes while clk_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            grp_q    <= '0;
            snap_q   <= '0;
            mask_q   <= '0;
            isr_q    <= '0;
            pend_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.clk_en) begin
            pend_q <= bus.irq;
            unique case (state_q)
                StIdle: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    if (bus.start) begin
                        unique case (opcode_e'(bus.n))
                            OpGetVector: begin
                                snap_q  <= get_snap;
                                grp_q   <= '0;
                                state_q <= StScan;
                            end
                            OpEoi: begin
                                isr_q    <= isr_q & (isr_q - OneIrq);
                                result_q <= (isr_q == '0) ? NO_IRQ_VECTOR : make_vector(isr_low);
                                done_q   <= 1'b1;
                                state_q  <= StResp;
                            end
                            OpWriteMask: begin
                                mask_q   <= bus.dataa[NUM_IRQ-1:0];
                                result_q <= 32'(mask_q);
                                done_q   <= 1'b1;
                                state_q  <= StResp;
                            end
                            OpReadStatus: begin
                                result_q <= 32'(pend_q & mask_q);
                                done_q   <= 1'b1;
                                state_q  <= StResp;
                            end
                        endcase
                    end
                end
                StScan: begin
                    if (enc_any) begin
                        isr_q    <= isr_q | (OneIrq << win_idx);
                        result_q <= make_vector(win_idx);
                        done_q   <= 1'b1;
                        state_q  <= StResp;
                    end else if (grp_q == LastGrp) begin
                        result_q <= NO_IRQ_VECTOR;
                        done_q   <= 1'b1;
                        state_q  <= StResp;
                    end else begin
                        grp_q <= grp_q + GrpW'(1);
                    end
                end
                StResp: begin
                    done_q   <= 1'b0;
                    result_q <= '0;
                    state_q  <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // done is masked by clk_en so a stalled response is only seen once the core resumes.
    assign bus.done   = done_q & bus.clk_en;
    assign bus.result = bus.done ? result_q : 32'h0;

endmodule

// File: tb/tb_irq_vector_scheduler.sv
// Self-checking bench for irq_vector_scheduler: directed scenarios plus randomized commands
// checked against a behavioural model of pending/mask/in-service sets.
module tb_irq_vector_scheduler;
    import irq_vector_pkg::*;

    localparam int NIRQ = 32;
    localparam int SW   = 8;
    localparam int NG   = NIRQ / SW;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [31:0] m_irq;
    logic [31:0] m_mask;
    logic [31:0] m_isr;

    irq_vector_scheduler_if #(.NUM_IRQ(NIRQ)) bus ();

    irq_vector_scheduler #(
        .NUM_IRQ    (NIRQ),
        .SCAN_WIDTH (SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Hold irq for one enabled cycle so the registered pending set reflects it.
    task automatic set_irq(input logic [31:0] v);
        bus.irq = v;
        m_irq   = v;
        tick();
    endtask

    // Reference behaviour: expected result and enabled-cycle latency, updating model state.
    task automatic model_cmd(input logic [1:0] op, input logic [31:0] d,
                             output logic [31:0] res, output int lat);
        int low;
        int win;
        low = NIRQ;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (m_isr[i]) low = i;
        end
        lat = 1;
        res = 32'h0;
        case (op)
            2'd0: begin
                win = -1;
                for (int i = 0; i < low; i++) begin
                    if (win < 0 && d[0] && m_irq[i] && m_mask[i]) win = i;
                end
                if (win >= 0) begin
                    res   = 32'(win * 8);
                    lat   = win / SW + 2;
                    m_isr = m_isr | (32'd1 << win);
                end else begin
                    res = 32'h8000_0000;
                    lat = NG + 1;
                end
            end
            2'd1: begin
                if (low < NIRQ) begin
                    res   = 32'(low * 8);
                    m_isr = m_isr & ~(32'd1 << low);
                end else begin
                    res = 32'h8000_0000;
                end
            end
            2'd2: begin
                res    = m_mask;
                m_mask = d;
            end
            default: res = m_irq & m_mask;
        endcase
    endtask

    // mode 0: no stalls; 1: random clk_en stalls; 2: stalls in cycles 2..4 and an extra
    // start strobe in cycle 1 that the scheduler must ignore.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] d, input int mode,
                           input string tag, output logic [31:0] res);
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        int          stalls;
        model_cmd(op, d, exp_res, exp_lat);
        bus.start = 1'b1;
        bus.n     = op;
        bus.dataa = d;
        lat       = 0;
        stalls    = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = (mode == 2 && lat == 1);
            bus.n     = (mode == 2 && lat == 1) ? 2'd1 : op;
            if (mode == 1)      bus.clk_en = ($urandom_range(0, 3) != 0);
            else if (mode == 2) bus.clk_en = !(lat >= 2 && lat <= 4);
            else                bus.clk_en = 1'b1;
            if (!bus.clk_en) stalls++;
            #1;
            if (bus.done === 1'b1) break;
            check({tag, ":quiet_result"}, bus.result, 64'h0);
            if (lat >= 100) begin
                check({tag, ":timeout_done"}, bus.done, 64'h1);
                break;
            end
        end
        res = bus.result;
        check({tag, ":latency"}, lat, exp_lat + stalls);
        check({tag, ":result"}, res, exp_res);
        bus.clk_en = 1'b1;
        bus.start  = 1'b0;
        tick();
        check({tag, ":done_pulse"}, bus.done, 64'h0);
        check({tag, ":isr"}, dut.isr_q, m_isr);
        check({tag, ":mask"}, dut.mask_q, m_mask);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] d;
        logic [1:0]  op;
        int          r;
        bit          seen;

        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        bus.clk_en = 1'b0;
        bus.start  = 1'b0;
        bus.n      = 2'd0;
        bus.dataa  = 32'h0;
        bus.irq    = 32'h0;
        m_irq      = 32'h0;
        m_mask     = 32'h0;
        m_isr      = 32'h0;

        // Reset must take effect even with clk_en low.
        tick();
        tick();
        bus.clk_en = 1'b1;
        tick();
        check("reset:done", bus.done, 64'h0);
        check("reset:result", bus.result, 64'h0);
        check("reset:isr", dut.isr_q, 64'h0);
        check("reset:mask", dut.mask_q, 64'h0);
        check("reset:pend", dut.pend_q, 64'h0);
        reset = 1'b0;

        // Mask write returns the previous mask; status is pending AND mask.
        set_irq(32'h0000_F0F0);
        run_cmd(2'd2, 32'h0000_FF00, 0, "wmask_from_reset", res);
        check("wmask_from_reset:lit", res, 64'h0);
        run_cmd(2'd3, 32'h0, 0, "read_status", res);
        check("read_status:lit", res, 64'h0000_F000);

        // Single source in group 0.
        run_cmd(2'd2, 32'hFFFF_FFFF, 0, "wmask_all", res);
        check("wmask_all:lit", res, 64'h0000_FF00);
        set_irq(32'h0000_0010);
        run_cmd(2'd0, 32'h1, 0, "get_g0", res);
        check("get_g0:lit", res, 64'h0000_0020);
        check("get_g0:isr_lit", dut.isr_q, 64'h10);

        // In-service nesting: only indices below the lowest in-service bit may win.
        set_irq(32'h0000_0030);
        run_cmd(2'd0, 32'h1, 0, "get_blocked", res);
        check("get_blocked:lit", res, 64'h8000_0000);
        set_irq(32'h0000_0031);
        run_cmd(2'd0, 32'h1, 0, "get_nested", res);
        check("get_nested:lit", res, 64'h0);
        check("get_nested:isr_lit", dut.isr_q, 64'h11);
        run_cmd(2'd1, 32'h0, 0, "eoi_0", res);
        check("eoi_0:lit", res, 64'h0);
        check("eoi_0:isr_lit", dut.isr_q, 64'h10);
        run_cmd(2'd1, 32'h0, 0, "eoi_4", res);
        check("eoi_4:lit", res, 64'h20);
        run_cmd(2'd1, 32'h0, 0, "eoi_empty", res);
        check("eoi_empty:lit", res, 64'h8000_0000);

        // Winner in the last group, then the same with interrupts disabled by estatus.
        set_irq(32'h0100_0000);
        run_cmd(2'd0, 32'h1, 0, "get_g3", res);
        check("get_g3:lit", res, 64'h0000_00C0);
        run_cmd(2'd1, 32'h0, 0, "eoi_24", res);
        run_cmd(2'd0, 32'h0, 0, "get_estatus0", res);
        check("get_estatus0:lit", res, 64'h8000_0000);

        // Stalls during SCAN delay done; an extra start mid-scan is ignored.
        set_irq(32'h8000_0000);
        run_cmd(2'd0, 32'h1, 2, "get_stall", res);
        check("get_stall:lit", res, 64'h0000_00F8);
        tick();
        tick();
        check("get_stall:no_extra_done", bus.done, 64'h0);
        check("get_stall:isr_kept", dut.isr_q, 64'h8000_0000);
        run_cmd(2'd1, 32'h0, 0, "eoi_31", res);

        // Reset in the second SCAN cycle aborts the command without a response.
        bus.start = 1'b1;
        bus.n     = 2'd0;
        bus.dataa = 32'h1;
        tick();
        bus.start = 1'b0;
        seen      = 1'b0;
        if (bus.done === 1'b1) seen = 1'b1;
        tick();
        reset = 1'b1;
        if (bus.done === 1'b1) seen = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done !== 1'b0) seen = 1'b1;
            tick();
        end
        check("reset_scan:no_done", seen, 64'h0);
        check("reset_scan:isr", dut.isr_q, 64'h0);
        check("reset_scan:mask", dut.mask_q, 64'h0);
        m_isr  = 32'h0;
        m_mask = 32'h0;
        run_cmd(2'd0, 32'h1, 0, "reset_scan:get", res);
        check("reset_scan:get_lit", res, 64'h8000_0000);

        // Randomized commands with random clk_en stalls.
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) set_irq($urandom & $urandom & $urandom);
            if (r < 5)      op = 2'd0;
            else if (r < 7) op = 2'd1;
            else if (r < 8) op = 2'd2;
            else            op = 2'd3;
            d = $urandom;
            if (op == 2'd0) d[0] = ($urandom_range(0, 4) != 0);
            run_cmd(op, d, 1, "random", res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
